// File: rtl/dut_rr_arbiter.sv
// dut_rr_arbiter: round-robin share of a serial DUT; gnt one cycle after req, resp_vld DUT_LAT cycles after gnt.
// No backpressure: requesters hold req until granted. Optional stats counters under DUT_ARB_STATS_EN.
module dut_rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int BURST_MAX = 16,
   parameter int DUT_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_bit,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  dut_in,
   input  logic                  dut_out,
   output logic                  resp_bit,
   output logic [NUM_REQ-1:0]    resp_vld,
   output logic                  busy
`ifdef DUT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] grant_cnt,
   output logic [15:0]           stall_cnt
`endif
);
   localparam int              IW         = $clog2(NUM_REQ);
   localparam logic [IW:0]     NUM_REQ_W  = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]   LAST_REQ   = IW'(NUM_REQ-1);
   localparam logic [7:0]      BURST_LAST = 8'(BURST_MAX-1);
   localparam logic [2:0]      DRAIN_LAST = (DUT_LAT > 0) ? 3'(DUT_LAT-1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [7:0]    burst_q, burst_d;
   logic [2:0]    drain_q, drain_d;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   logic          own_req;
   logic [IW:0]   cand;

   // Descending scan so the lowest offset from the pointer wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (req[cand[IW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[IW-1:0];
         end
      end
   end

   assign own_req = req[owner_q];

   always_comb begin
      gnt    = '0;
      dut_in = 1'b0;
      if (state_q == S_GRANT && own_req) begin
         gnt[owner_q] = 1'b1;
         dut_in       = req_bit[owner_q];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            burst_d = '0;
            if (pick_vld) begin
               owner_d = pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!own_req || burst_q == BURST_LAST) begin
               state_d = (DUT_LAT == 0) ? S_IDLE : S_DRAIN;
               drain_d = '0;
               ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
            end else begin
               burst_d = burst_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = S_IDLE;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         drain_q <= drain_d;
      end
   end

   assign busy = (state_q != S_IDLE);

   // The one-hot grant doubles as the valid flag in each pipeline stage.
   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign resp_vld = gnt;
      end else begin : g_lat
         logic [NUM_REQ-1:0] pipe_q [DUT_LAT];
         logic [NUM_REQ-1:0] pipe_d [DUT_LAT];

         always_comb begin
            pipe_d[0] = gnt;
            for (int i = 1; i < DUT_LAT; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DUT_LAT; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign resp_vld = pipe_q[DUT_LAT-1];
      end
   endgenerate

   assign resp_bit = dut_out & (|resp_vld);

`ifdef DUT_ARB_STATS_EN
   logic [15:0] gcnt_q [NUM_REQ];
   logic [15:0] gcnt_d [NUM_REQ];
   logic [15:0] stall_q, stall_d;

   always_comb begin
      gcnt_d  = gcnt_q;
      stall_d = stall_q;
      if (state_q == S_IDLE && pick_vld && gcnt_q[pick_idx] != 16'hFFFF) begin
         gcnt_d[pick_idx] = gcnt_q[pick_idx] + 16'd1;
      end
      if ((|req) && gnt == '0 && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_q[i] <= '0;
         end
         stall_q <= '0;
      end else begin
         gcnt_q  <= gcnt_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_cnt[i*16 +: 16] = gcnt_q[i];
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dut_rr_arbiter.sv
// Scoreboard bench: u_dut (DUT_LAT=1, BURST_MAX=4, 1-cycle inverter DUT) and u_dut0 (DUT_LAT=0, combinational inverter).
module tb_dut_rr_arbiter;
   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic [3:0] req       = '0;
   logic [3:0] req_bit   = '0;
   logic [3:0] gnt, resp_vld;
   logic       dut_in, resp_bit, busy;
   logic       dut_out   = 1'b0;
   logic [3:0] req0      = '0;
   logic [3:0] req_bit0  = '0;
   logic [3:0] gnt0, resp_vld0;
   logic       dut_in0, dut_out0, resp_bit0, busy0;
`ifdef DUT_ARB_STATS_EN
   logic [63:0] grant_cnt, grant_cnt0;
   logic [15:0] stall_cnt, stall_cnt0;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   bit mon_en = 1'b1;

   typedef struct {int own; int len; int gap;} gexp_t;
   typedef struct {logic [3:0] vld; logic b;} rexp_t;
   gexp_t gq[$];
   rexp_t rq[$];
   rexp_t rq0[$];

   always #5 clk = ~clk;
   always @(posedge clk) dut_out <= ~dut_in;
   assign dut_out0 = ~dut_in0;

   dut_rr_arbiter #(.NUM_REQ(4), .BURST_MAX(4), .DUT_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_bit(req_bit), .gnt(gnt),
      .dut_in(dut_in), .dut_out(dut_out), .resp_bit(resp_bit),
      .resp_vld(resp_vld), .busy(busy)
`ifdef DUT_ARB_STATS_EN
      , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
   );

   dut_rr_arbiter #(.NUM_REQ(4), .BURST_MAX(4), .DUT_LAT(0)) u_dut0 (
      .clk(clk), .reset(reset), .req(req0), .req_bit(req_bit0), .gnt(gnt0),
      .dut_in(dut_in0), .dut_out(dut_out0), .resp_bit(resp_bit0),
      .resp_vld(resp_vld0), .busy(busy0)
`ifdef DUT_ARB_STATS_EN
      , .grant_cnt(grant_cnt0), .stall_cnt(stall_cnt0)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_g(input int own, input int len, input int gap);
      gexp_t e;
      e.own = own; e.len = len; e.gap = gap;
      gq.push_back(e);
   endtask

   task automatic push_r(input logic [3:0] vld, input logic b, input int n);
      rexp_t e;
      e.vld = vld; e.b = b;
      for (int i = 0; i < n; i++) rq.push_back(e);
   endtask

   task automatic push_r0(input logic [3:0] vld, input logic b, input int n);
      rexp_t e;
      e.vld = vld; e.b = b;
      for (int i = 0; i < n; i++) rq0.push_back(e);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (k < 60 && (busy || gq.size() != 0 || rq.size() != 0)) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_grant_q_empty"}, gq.size(), 0);
      chk({tag, "_resp_q_empty"}, rq.size(), 0);
      cyc(2);
   endtask

   // Grant monitor: owner, burst length and gap before each burst.
   int         cur_len = 0;
   int         gap_cnt = 0;
   logic [3:0] prev_gnt = '0;
   gexp_t      cur;
   always @(negedge clk) begin
      if (!mon_en) begin
         cur_len  = 0;
         gap_cnt  = 0;
         prev_gnt = '0;
      end else begin
         if (cur_len > 0 && gnt != prev_gnt) begin
            if (cur.len >= 0) chk("grant_len", cur_len, cur.len);
            cur_len = 0;
            gap_cnt = 0;
         end
         if (gnt != '0) begin
            if (cur_len == 0) begin
               if (gq.size() == 0) begin
                  chk("grant_unexpected", 32'(gnt), 32'd0);
                  cur.len = -1;
               end else begin
                  cur = gq.pop_front();
                  chk("grant_owner", 32'(gnt), 32'd1 << cur.own);
                  if (cur.gap >= 0) chk("grant_gap", gap_cnt, cur.gap);
               end
            end
            cur_len++;
         end else begin
            gap_cnt++;
         end
         prev_gnt = gnt;
      end
   end

   // Response monitors.
   always @(negedge clk) begin
      rexp_t e;
      if (mon_en && resp_vld != '0) begin
         if (rq.size() == 0) begin
            chk("resp_unexpected", 32'(resp_vld), 32'd0);
         end else begin
            e = rq.pop_front();
            chk("resp_vld", 32'(resp_vld), 32'(e.vld));
            chk("resp_bit", 32'(resp_bit), 32'(e.b));
         end
      end
   end

   always @(negedge clk) begin
      rexp_t e;
      if (resp_vld0 != '0) begin
         chk("lat0_resp_with_gnt", 32'(resp_vld0), 32'(gnt0));
         if (rq0.size() == 0) begin
            chk("lat0_resp_unexpected", 32'(resp_vld0), 32'd0);
         end else begin
            e = rq0.pop_front();
            chk("lat0_resp_vld", 32'(resp_vld0), 32'(e.vld));
            chk("lat0_resp_bit", 32'(resp_bit0), 32'(e.b));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] pat;
      pat = 4'b1101;

      // Reset state
      cyc(2);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_resp_vld", 32'(resp_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      chk("rst_resp_bit", 32'(resp_bit), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(2);

      // Round robin, all requesting: 0,1,2,3,0 with 4-cycle bursts and 2-cycle gaps
      push_g(0, 4, -1);
      push_g(1, 4, 2);
      push_g(2, 4, 2);
      push_g(3, 4, 2);
      push_g(0, 4, 2);
      push_r(4'b0001, 1'b1, 4);
      push_r(4'b0010, 1'b1, 4);
      push_r(4'b0100, 1'b1, 4);
      push_r(4'b1000, 1'b1, 4);
      push_r(4'b0001, 1'b1, 4);
      req = 4'b1111; req_bit = 4'b0000;
      cyc(29);
      req = 4'b0000;
      wait_idle("rr");

      // Early release of requester 2 after 3 drive cycles
      push_g(2, 3, -1);
      push_r(4'b0100, 1'b0, 3);
      req = 4'b0100; req_bit = 4'b0100;
      cyc(4);
      req = 4'b0000;
      @(negedge clk);
      chk("rel_busy_grant", 32'(busy), 32'd1);
      chk("rel_gnt_masked", 32'(gnt), 32'd0);
      chk("rel_dut_in_masked", 32'(dut_in), 32'd0);
      cyc(1);
      @(negedge clk);
      chk("rel_busy_drain", 32'(busy), 32'd1);
      cyc(1);
      @(negedge clk);
      chk("rel_idle", 32'(busy), 32'd0);
      cyc(1);
      req_bit = 4'b0000;
      wait_idle("rel");

      // Pointer at 3, req 0101 -> 0 then 2; then only 0 -> re-granted after drain
      push_g(0, 4, -1);
      push_g(2, 4, 2);
      push_g(0, 4, 2);
      push_r(4'b0001, 1'b1, 4);
      push_r(4'b0100, 1'b1, 4);
      push_r(4'b0001, 1'b1, 4);
      req = 4'b0101;
      cyc(11);
      req = 4'b0001;
      cyc(6);
      req = 4'b0000;
      wait_idle("wrap");

      // Data path: requester 1 drives 1,0,1,1 through the inverter
      push_g(1, 4, -1);
      push_r(4'b0010, 1'b0, 1);
      push_r(4'b0010, 1'b1, 1);
      push_r(4'b0010, 1'b0, 2);
      req = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         req_bit = {2'b00, pat[k], 1'b0};
      end
      cyc(1);
      req = 4'b0000; req_bit = 4'b0000;
      wait_idle("data");

`ifdef DUT_ARB_STATS_EN
      chk("stats_gcnt0", 32'(grant_cnt[15:0]), 32'd4);
      chk("stats_gcnt1", 32'(grant_cnt[31:16]), 32'd2);
      chk("stats_gcnt2", 32'(grant_cnt[47:32]), 32'd3);
      chk("stats_gcnt3", 32'(grant_cnt[63:48]), 32'd1);
      chk("stats_stall", 32'(stall_cnt), 32'd16);
`endif

      // Reset for 2 cycles in the middle of a grant to requester 2
      mon_en = 1'b0;
      req = 4'b1111;
      cyc(2);
      reset = 1'b1;
      cyc(1);
      @(negedge clk);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_resp_vld", 32'(resp_vld), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      cyc(1);
      reset = 1'b0;
      cyc(1);
      @(negedge clk);
      chk("mid_rst_next_gnt", 32'(gnt), 32'd1);
      cyc(1);
      req = 4'b0000;
      cyc(8);

      // Zero-latency instance: 0 then 1 back to back, 1-cycle handover gap
      push_r0(4'b0001, 1'b0, 4);
      push_r0(4'b0010, 1'b1, 4);
      req0 = 4'b0011; req_bit0 = 4'b0001;
      cyc(4);
      @(negedge clk);
      chk("lat0_gnt_last0", 32'(gnt0), 32'd1);
      cyc(1);
      @(negedge clk);
      chk("lat0_gap_gnt", 32'(gnt0), 32'd0);
      chk("lat0_gap_busy", 32'(busy0), 32'd0);
      cyc(1);
      @(negedge clk);
      chk("lat0_gnt_first1", 32'(gnt0), 32'd2);
      cyc(4);
      req0 = 4'b0000; req_bit0 = 4'b0000;
      cyc(3);
      chk("lat0_resp_q_empty", rq0.size(), 0);
      chk("lat0_idle", 32'(busy0), 32'd0);
`ifdef DUT_ARB_STATS_EN
      chk("lat0_gcnt0", 32'(grant_cnt0[15:0]), 32'd1);
      chk("lat0_gcnt1", 32'(grant_cnt0[31:16]), 32'd1);
      chk("lat0_stall", 32'(stall_cnt0), 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dut_rr_arbiter.md
Name: dut_rr_arbiter

Overview:
Round-robin arbiter that shares the single-bit serial DUT datapath (dut_in -> dut_out) among NUM_REQ requesters. It grants one requester at a time for a bounded burst and muxes that requester's bit onto dut_in. It routes dut_out back to the owner after a fixed DUT latency, and drains in-flight bits before handing over ownership. It sits between the stimulus sources and the DUT in the simulation/integration top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BURST_MAX, 16, maximum consecutive drive cycles per grant (1..255)
DUT_LAT, 1, cycles from dut_in sample to valid dut_out (0..7)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  per-requester request; held high while it has bits to drive
req_bit  input  NUM_REQ  per-requester serial data bit
gnt  output  NUM_REQ  one-hot grant; the granted requester's bit is driven this cycle
dut_in  output  1  muxed bit to DUT
dut_out  input  1  DUT output
resp_bit  output  1  dut_out forwarded to owner
resp_vld  output  NUM_REQ  one-hot; asserted DUT_LAT cycles after the matching gnt cycle
busy  output  1  high in GRANT or DRAIN

Behaviour:
- Reset (sync, clk edge with reset=1) drives outputs to: gnt=0, dut_in=0, resp_vld=0, resp_bit=0, busy=0, state=IDLE, rr pointer=0, burst counter=0, latency pipeline cleared.
- FSM states: IDLE, GRANT, DRAIN.
- IDLE: if any req, pick first set bit at or after the rr pointer (wrapping modulo NUM_REQ). Registered: gnt asserted the next cycle and state goes to GRANT. burst_cnt=0.
- GRANT: dut_in = req_bit[owner] (combinational from gnt). burst_cnt increments each cycle. Leave GRANT when req[owner]=0 (that cycle is not counted as a drive cycle; gnt drops combinationally-masked, dut_in=0) or when burst_cnt reaches BURST_MAX-1. On leaving, state goes to DRAIN, rr pointer = owner+1 mod NUM_REQ.
- Maximum grant is exactly BURST_MAX drive cycles.
- DRAIN: gnt=0, dut_in=0 for DUT_LAT cycles. The cycle after the counter expires, return to IDLE. DUT_LAT=0 skips DRAIN (GRANT->IDLE).
- Handover gap is at minimum 1 + DUT_LAT cycles with no grant.
- Response path: shift register of depth DUT_LAT carries {valid, owner one-hot}. resp_vld = tail entry, resp_bit = dut_out. For DUT_LAT=0, resp_vld = gnt qualified by req[owner].
- A requester dropping and re-raising req still waits for its round-robin turn; no re-grant while others are pending.
- Single requester: it is re-granted after DRAIN with no starvation limit.
- Reset mid-GRANT/DRAIN: in-flight responses are discarded (resp_vld=0 next cycle), and the pointer returns to 0.
- gnt is always one-hot or zero. resp_vld is always one-hot or zero.

Optional Feature:
Macro DUT_ARB_STATS_EN.
- With it: per-requester 16-bit grant counters (saturating at 16'hFFFF) and one 16-bit stall counter. The stall counter increments each cycle any req is high with gnt=0. These are exposed on output grant_cnt [NUM_REQ*16] and output stall_cnt [16], and all counters clear on reset.
- Without it: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles during an active grant -> gnt=0, resp_vld=0, busy=0 the cycle after the edge, and the next grant goes to req[0].
- Round-robin with NUM_REQ=4, DUT_LAT=1, BURST_MAX=4: req=4'b1111 held -> grant order 0,1,2,3,0. Each grant lasts 4 cycles, with a 2-cycle gap between grants.
- Early release: req[2] alone, drops after 3 drive cycles -> exactly 3 gnt cycles. resp_vld[2] pulses 3 times, each delayed 1 cycle. Then DRAIN of 1 cycle, then IDLE.
- Data path: requester 1 drives pattern 1,0,1,1 with the DUT modelled as a 1-cycle inverter -> resp_bit sequence 0,1,0,0 with resp_vld[1]=1 on those cycles only.
- Wrap/pointer: pointer at 3, req=4'b0101 -> grant order 0 then 2. Then req=4'b0001 only -> 0 is re-granted after the DRAIN gap.
- DUT_LAT=0 build: back-to-back req[0] and req[1] -> handover gap exactly 1 cycle, resp_vld coincident with gnt. With DUT_ARB_STATS_EN, grant_cnt[0]=grant_cnt[1]=1.
